// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory arbiter slice.
//   - default address/data widths of the shared 64K x 8 memory
//   - default starvation limit for the DMA port
//   - port-select enum used by the address/data mux
//   - bit positions of the CPU and DMA lanes in the REQ/GNT vectors
package mem_pkg;

    localparam int ADDR_W_DEF   = 16;
    localparam int DATA_W_DEF   = 8;
    localparam int MAX_WAIT_DEF = 4;

    // Lane positions inside the 2-bit request/grant vectors.
    localparam int REQ_C = 1;
    localparam int REQ_D = 0;

    typedef enum logic {
        SEL_CPU = 1'b0,
        SEL_DMA = 1'b1
    } sel_e;

endpackage

// File: rtl/arb_prio_starve.sv
// arb_prio_starve: fixed-priority two-way arbiter (CPU over DMA) with a
// starvation counter that forces a DMA win after MAX_WAIT lost contests.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset; also forces both grants low
//   req    in   [1] CPU request, [0] DMA request
//   gnt    out  [1] CPU grant,   [0] DMA grant (one-hot or zero)
module arb_prio_starve
    import mem_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

    logic [3:0] wait_q;
    logic [3:0] wait_d;

    // Grants are purely combinational so an access issues in the same cycle
    // as its request; gating with rst_n keeps them low during reset.
    always_comb begin
        gnt = 2'b00;
        if (rst_n) begin
            if (req[REQ_C] && req[REQ_D]) begin
                if (wait_q == WAIT_LIM) begin
                    gnt[REQ_D] = 1'b1;
                end else begin
                    gnt[REQ_C] = 1'b1;
                end
            end else if (req[REQ_C]) begin
                gnt[REQ_C] = 1'b1;
            end else if (req[REQ_D]) begin
                gnt[REQ_D] = 1'b1;
            end
        end
    end

    // The count only measures an unbroken run of lost contests: it restarts
    // whenever DMA wins or stops asking.
    always_comb begin
        wait_d = wait_q;
        if (!req[REQ_D] || gnt[REQ_D]) begin
            wait_d = 4'd0;
        end else if (gnt[REQ_C] && (wait_q < WAIT_LIM)) begin
            wait_d = wait_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= 4'd0;
        end else begin
            wait_q <= wait_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port synchronous memory (registered read
// data, one cycle latency) between the 6502 core (C_*) and a DMA/loader
// engine (D_*). One access is issued per cycle; read data is broadcast on
// both RDATA buses and qualified by the RVALID of the port that issued it.
//
// Ports:
//   CLK, RESET_N                 clock, asynchronous active-low reset
//   C_REQ/C_WE/C_ADDR/C_WDATA    CPU request, held stable until C_GNT
//   C_GNT, C_RVALID, C_RDATA     CPU grant, read-data valid, read data
//   D_*                          same set for the DMA port
//   MEM_WE/MEM_ADDR/MEM_DIN      to the memory
//   MEM_DOUT                     from the memory, valid the cycle after address
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              CLK,
    input  logic              RESET_N,

    input  logic              C_REQ,
    input  logic              C_WE,
    input  logic [ADDR_W-1:0] C_ADDR,
    input  logic [DATA_W-1:0] C_WDATA,
    output logic              C_GNT,
    output logic              C_RVALID,
    output logic [DATA_W-1:0] C_RDATA,

    input  logic              D_REQ,
    input  logic              D_WE,
    input  logic [ADDR_W-1:0] D_ADDR,
    input  logic [DATA_W-1:0] D_WDATA,
    output logic              D_GNT,
    output logic              D_RVALID,
    output logic [DATA_W-1:0] D_RDATA,

    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_DIN,
    input  logic [DATA_W-1:0] MEM_DOUT
);

    logic [1:0] req;
    logic [1:0] gnt;
    sel_e       sel_q;
    sel_e       cur_sel;
    logic [1:0] rd_tag_q;

    assign req[REQ_C] = C_REQ;
    assign req[REQ_D] = D_REQ;

    arb_prio_starve #(
        .MAX_WAIT (MAX_WAIT)
    ) u_arb (
        .clk   (CLK),
        .rst_n (RESET_N),
        .req   (req),
        .gnt   (gnt)
    );

    assign C_GNT = gnt[REQ_C];
    assign D_GNT = gnt[REQ_D];

    // With no grant the mux keeps pointing at the last winner so the memory
    // address/data buses do not toggle needlessly.
    always_comb begin
        cur_sel = sel_q;
        if (C_GNT) begin
            cur_sel = SEL_CPU;
        end else if (D_GNT) begin
            cur_sel = SEL_DMA;
        end
    end

    assign MEM_ADDR = (cur_sel == SEL_DMA) ? D_ADDR  : C_ADDR;
    assign MEM_DIN  = (cur_sel == SEL_DMA) ? D_WDATA : C_WDATA;
    assign MEM_WE   = (C_GNT & C_WE) | (D_GNT & D_WE);

    // rd_tag remembers which port issued a read so the registered memory
    // output one cycle later is qualified for that port only.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sel_q    <= SEL_CPU;
            rd_tag_q <= 2'b00;
        end else begin
            sel_q    <= cur_sel;
            rd_tag_q <= {C_GNT & ~C_WE, D_GNT & ~D_WE};
        end
    end

    assign C_RVALID = rd_tag_q[1];
    assign D_RVALID = rd_tag_q[0];
    assign C_RDATA  = MEM_DOUT;
    assign D_RDATA  = MEM_DOUT;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter with a
// behavioural 64K x 8 registered-read memory attached.
module tb_mem_arbiter;

    logic        CLK;
    logic        RESET_N;
    logic        C_REQ, C_WE, C_GNT, C_RVALID;
    logic [15:0] C_ADDR;
    logic [7:0]  C_WDATA, C_RDATA;
    logic        D_REQ, D_WE, D_GNT, D_RVALID;
    logic [15:0] D_ADDR;
    logic [7:0]  D_WDATA, D_RDATA;
    logic        MEM_WE;
    logic [15:0] MEM_ADDR;
    logic [7:0]  MEM_DIN, MEM_DOUT;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];
    logic [7:0] cq [$];
    logic [7:0] dq [$];
    logic       last_dma;

    mem_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_WAIT(4)) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .C_REQ    (C_REQ),
        .C_WE     (C_WE),
        .C_ADDR   (C_ADDR),
        .C_WDATA  (C_WDATA),
        .C_GNT    (C_GNT),
        .C_RVALID (C_RVALID),
        .C_RDATA  (C_RDATA),
        .D_REQ    (D_REQ),
        .D_WE     (D_WE),
        .D_ADDR   (D_ADDR),
        .D_WDATA  (D_WDATA),
        .D_GNT    (D_GNT),
        .D_RVALID (D_RVALID),
        .D_RDATA  (D_RDATA),
        .MEM_WE   (MEM_WE),
        .MEM_ADDR (MEM_ADDR),
        .MEM_DIN  (MEM_DIN),
        .MEM_DOUT (MEM_DOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous memory: write on the edge, registered read data.
    always @(posedge CLK) begin
        if (MEM_WE) mem[MEM_ADDR] <= MEM_DIN;
        MEM_DOUT <= mem[MEM_ADDR];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents read data.
    always @(negedge CLK) begin
        if (C_RVALID === 1'b1) begin
            if (cq.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL c_rvalid_unexpected: got 1 expected 0 (data %0h)", C_RDATA);
            end else begin
                check("c_rdata", {24'd0, C_RDATA}, {24'd0, cq.pop_front()});
            end
        end
        if (D_RVALID === 1'b1) begin
            if (dq.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL d_rvalid_unexpected: got 1 expected 0 (data %0h)", D_RDATA);
            end else begin
                check("d_rdata", {24'd0, D_RDATA}, {24'd0, dq.pop_front()});
            end
        end
    end

    // One bus cycle: check grant/mux at the falling edge against the expected
    // winner, record expected read data, then advance past the rising edge.
    task automatic cyc(input logic ec, input logic ed, input string tag);
        logic [15:0] ea;
        logic [7:0]  ed_in;
        logic        ewe;
        @(negedge CLK);
        check({tag, "_c_gnt"}, {31'd0, C_GNT}, {31'd0, ec});
        check({tag, "_d_gnt"}, {31'd0, D_GNT}, {31'd0, ed});
        ewe = (ec & C_WE) | (ed & D_WE);
        check({tag, "_mem_we"}, {31'd0, MEM_WE}, {31'd0, ewe});
        if (ec) begin
            last_dma = 1'b0;
        end else if (ed) begin
            last_dma = 1'b1;
        end
        ea    = last_dma ? D_ADDR  : C_ADDR;
        ed_in = last_dma ? D_WDATA : C_WDATA;
        check({tag, "_mem_addr"}, {16'd0, MEM_ADDR}, {16'd0, ea});
        if (ewe) begin
            check({tag, "_mem_din"}, {24'd0, MEM_DIN}, {24'd0, ed_in});
            ref_mem[ea] = ed_in;
        end
        if (ec && !C_WE) cq.push_back(ref_mem[C_ADDR]);
        if (ed && !D_WE) dq.push_back(ref_mem[D_ADDR]);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 8'(i) ^ 8'(i >> 8) ^ 8'h33;
            ref_mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h33;
        end
        mem[0]     = 8'hA2;
        ref_mem[0] = 8'hA2;
        last_dma   = 1'b0;

        // Reset state, with a CPU write request already pending.
        RESET_N = 1'b0;
        C_REQ = 1'b1; C_WE = 1'b1; C_ADDR = 16'h1234; C_WDATA = 8'h11;
        D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 16'h4321; D_WDATA = 8'h22;
        #3;
        check("rst_c_gnt",    {31'd0, C_GNT},    32'd0);
        check("rst_d_gnt",    {31'd0, D_GNT},    32'd0);
        check("rst_mem_we",   {31'd0, MEM_WE},   32'd0);
        check("rst_c_rvalid", {31'd0, C_RVALID}, 32'd0);
        check("rst_d_rvalid", {31'd0, D_RVALID}, 32'd0);
        check("rst_mem_addr", {16'd0, MEM_ADDR}, 32'h1234);
        C_REQ = 1'b0; D_REQ = 1'b0; C_WE = 1'b0; D_WE = 1'b0;
        @(posedge CLK); @(posedge CLK); #1;
        RESET_N = 1'b1;
        cyc(1'b0, 1'b0, "idle");

        // Test 1: CPU read of 0x0000 -> 0xA2 one cycle later.
        C_REQ = 1'b1; C_WE = 1'b0; C_ADDR = 16'h0000;
        cyc(1'b1, 1'b0, "t1_rd");
        C_REQ = 1'b0;
        cyc(1'b0, 1'b0, "t1_ret");

        // Test 2: DMA write 0x5A to 0x0200, then read it back; bus holds DMA
        // address once idle even though C_ADDR moves.
        D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 16'h0200; D_WDATA = 8'h5A;
        cyc(1'b0, 1'b1, "t2_wr");
        D_WE = 1'b0;
        cyc(1'b0, 1'b1, "t2_rd");
        D_REQ = 1'b0; C_ADDR = 16'h0777;
        cyc(1'b0, 1'b0, "t2_hold");
        cyc(1'b0, 1'b0, "t2_idle");

        // Test 3: both read continuously -> C,C,C,C,D repeating.
        C_REQ = 1'b1; C_WE = 1'b0; C_ADDR = 16'h0010;
        D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 16'h0020;
        for (int i = 0; i < 10; i++) begin
            cyc((i % 5) != 4, (i % 5) == 4, "t3");
        end
        C_REQ = 1'b0; D_REQ = 1'b0;
        cyc(1'b0, 1'b0, "t3_drain");

        // Test 6: DMA drops after three lost contests; count restarts.
        C_REQ = 1'b1; D_REQ = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, "t6_pre");
        D_REQ = 1'b0;
        cyc(1'b1, 1'b0, "t6_drop");
        D_REQ = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, "t6_post");
        cyc(1'b0, 1'b1, "t6_dwin");
        C_REQ = 1'b0; D_REQ = 1'b0;
        cyc(1'b0, 1'b0, "t6_drain");

        // Test 4: CPU write and DMA read of 0x0106 contend; CPU first, DMA
        // then sees the freshly written value.
        C_REQ = 1'b1; C_WE = 1'b1; C_ADDR = 16'h0106; C_WDATA = 8'h3C;
        D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 16'h0106;
        cyc(1'b1, 1'b0, "t4_cwr");
        C_REQ = 1'b0; C_WE = 1'b0;
        cyc(1'b0, 1'b1, "t4_drd");
        D_REQ = 1'b0;
        cyc(1'b0, 1'b0, "t4_ret");
        check("t4_ref", {24'd0, ref_mem[16'h0106]}, 32'h3C);

        // Test 5: reset asserted the cycle after a CPU read grant.
        C_REQ = 1'b1; C_WE = 1'b0; C_ADDR = 16'h0000;
        cyc(1'b1, 1'b0, "t5_rd");
        RESET_N = 1'b0;
        cq.delete();
        dq.delete();
        last_dma = 1'b0;
        C_WE = 1'b1; D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 16'h0300;
        #1;
        check("t5_c_rvalid", {31'd0, C_RVALID}, 32'd0);
        check("t5_c_gnt",    {31'd0, C_GNT},    32'd0);
        check("t5_d_gnt",    {31'd0, D_GNT},    32'd0);
        check("t5_mem_we",   {31'd0, MEM_WE},   32'd0);
        check("t5_mem_addr", {16'd0, MEM_ADDR}, 32'h0000);
        C_REQ = 1'b0; C_WE = 1'b0; D_REQ = 1'b0; D_WE = 1'b0;
        @(posedge CLK); @(posedge CLK); #1;
        RESET_N = 1'b1;
        cyc(1'b0, 1'b0, "t5_post0");
        cyc(1'b0, 1'b0, "t5_post1");
        C_REQ = 1'b1; C_ADDR = 16'h0000;
        cyc(1'b1, 1'b0, "t5_t1_rd");
        C_REQ = 1'b0;
        cyc(1'b0, 1'b0, "t5_t1_ret");
        cyc(1'b0, 1'b0, "t5_end");

        check("c_queue_empty", cq.size(), 32'd0);
        check("d_queue_empty", dq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port synchronous 64K x 8 memory between two requesters: the 6502 core (port C) and a DMA/loader engine (port D).
- Per cycle, it selects one requester, drives the memory address, write-enable and write-data, and routes the one-cycle-latency registered read data back to the requester that issued the read.
- CPU has priority; a starvation counter guarantees DMA progress.

Parameters:
- ADDR_W, 16, address width (memory is 2^ADDR_W bytes)
- DATA_W, 8, data width
- MAX_WAIT, 4, consecutive contested cycles DMA may lose before it is forced a win (1..15)

Ports:
- CLK  in  1  system clock, all state on posedge
- RESET_N  in  1  asynchronous active-low reset
- C_REQ  in  1  CPU access request, level, held until C_GNT
- C_WE  in  1  CPU write (1) / read (0)
- C_ADDR  in  ADDR_W  CPU address
- C_WDATA  in  DATA_W  CPU write data
- C_GNT  out  1  CPU access issued this cycle
- C_RVALID  out  1  C_RDATA valid (read issued previous cycle)
- C_RDATA  out  DATA_W  CPU read data
- D_REQ, D_WE, D_ADDR, D_WDATA, D_GNT, D_RVALID, D_RDATA: same as the C_* ports, for DMA
- MEM_WE  out  1  to memory WE
- MEM_ADDR  out  ADDR_W  to memory Address
- MEM_DIN  out  DATA_W  to memory DataIn
- MEM_DOUT  in  DATA_W  from memory DataOut (registered, valid the cycle after the address)

Behaviour:
- Grant logic (combinational from REQ and registered state):
  - Only C_REQ: C_GNT=1.
  - Only D_REQ: D_GNT=1.
  - Both: D_GNT=1 if wait_cnt==MAX_WAIT, else C_GNT=1.
  - Neither: no grant.
  - C_GNT and D_GNT are never both 1.
- Both grants are forced to 0 while RESET_N=0.
- Mux:
  - MEM_ADDR/MEM_DIN follow the granted port.
  - With no grant, they hold the last granted port's values (sel register), which avoids needless toggling.
  - MEM_WE = (C_GNT & C_WE) | (D_GNT & D_WE). It is never 1 without a grant.
- wait_cnt (4-bit register):
  - Increments when D_REQ & C_GNT.
  - Clears when D_GNT, or when D_REQ=0.
  - Saturates at MAX_WAIT.
- Read return:
  - Registers rd_tag = {C_GNT & ~C_WE, D_GNT & ~D_WE}.
  - Next cycle: C_RVALID = rd_tag[1], D_RVALID = rd_tag[0].
  - C_RDATA = D_RDATA = MEM_DOUT (broadcast; valid only with the matching RVALID).
  - Read latency: GNT cycle + 1.
  - Writes produce no RVALID.
- Back-to-back: one access per cycle sustained. A read after a write to the same address in the next cycle returns the new data (the memory updates on the write edge).
- Same-cycle write then read on different ports is ordered by grant only; no hazard logic beyond this.
- Requester contract:
  - Drive address, WE and WDATA stable while REQ=1.
  - Drop or advance on the cycle after GNT is seen.
  - REQ may stay high for back-to-back accesses.
- Reset (async assert, sync-safe deassert): wait_cnt=0, rd_tag=0, sel=CPU.
  - Outputs during reset: all GNT=0, RVALID=0, MEM_WE=0, MEM_ADDR=C_ADDR.
- Reset mid-read: any pending RVALID is dropped, and no RVALID appears after deassert.

Decomposition:
- Shared package mem_pkg: ADDR_W/DATA_W defaults, port-select enum {SEL_CPU, SEL_DMA}, and the MAX_WAIT default.
- One natural sub-module, arb_prio_starve: grant logic plus wait_cnt, with inputs REQ[1:0] and outputs GNT[1:0]. The mux and read-tag logic stay in mem_arbiter.
- The top level instantiates mem_arbiter next to the existing memory.

Test Plan:
1. Reset, then CPU only, C_REQ read of 0x0000 (contents 0xA2):
   - C_GNT=1 in cycle 0.
   - C_RVALID=1 with C_RDATA=0xA2 in cycle 1.
   - D_RVALID=0 throughout.
2. DMA only, write 0x5A to 0x0200 then read 0x0200 back-to-back:
   - MEM_WE=1 in cycle 0.
   - D_RVALID=1 with D_RDATA=0x5A in cycle 2.
3. Both requesting reads continuously, MAX_WAIT=4:
   - Grant pattern C,C,C,C,D repeating.
   - wait_cnt reaches 4 then clears.
   - Each RVALID is routed to the correct port with the correct data.
4. CPU write to 0x0106 and DMA read of 0x0106 both pending, wait_cnt=0:
   - CPU wins.
   - DMA granted next cycle (C_REQ dropped) and reads the new value.
5. Assert RESET_N=0 one cycle after a CPU read grant:
   - C_RVALID stays 0.
   - All GNT and MEM_WE are 0 immediately (asynchronously).
   - After release, the first access behaves as in test 1.
6. D_REQ drops while wait_cnt=3:
   - wait_cnt clears.
   - When D_REQ reasserts, the count restarts from 0.
